multicycle_cu: RTL

Parametrised multi-cycle control unit: next generation of the single-cycle decoder, sequencing each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready handshake to instruction/data memory. Sits between the instruction register and the datapath, drives the PC, IR, register-file and memory enables, and keeps a retired-instruction count and sticky fault flags. Same opcode map and ALU control encoding as the single-cycle unit, plus wait states, timeout and illegal-opcode trapping.

---
 rtl/multicycle_cu.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// with a mem_ready handshake, wait-state timeout, illegal-opcode trap and retire counter.
module multicycle_cu #(
  parameter int OPW     = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic             branch,
  output logic [1:0]       alu_control,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADDI  = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;
  localparam logic [2:0] OP_STORE = 3'd6;
  localparam logic [2:0] OP_BEQ   = 3'd7;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             wait_expired;
  logic             opcode_legal;

  assign opcode_legal = (opcode[OPW-1:3] == '0);
  // Last permitted wait cycle: a ready on this cycle still completes normally.
  assign wait_expired = (wait_q == WCW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode[2:0];
        if (opcode_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_expired) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are decoded from the current state and gated off while reset is held.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    branch      = 1'b0;
    alu_control = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (op_q)
            OP_ADDI, OP_LOAD, OP_STORE: alu_src = 1'b1;
            OP_BEQ: begin
              alu_control = 2'b01;
              branch      = 1'b1;
              pc_write    = zero;
            end
            default: alu_control = op_q[1:0];
          endcase
        end
        S_MEM: begin
          alu_src   = 1'b1;
          mem_read  = (op_q == OP_LOAD);
          mem_write = (op_q == OP_STORE);
        end
        S_WB:    reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule
